// File: rtl/mem_lsu.sv
// Load/store unit: splits word/half/byte requests into little-endian byte
// transfers on a byte-wide memory port and returns extended load data.
module mem_lsu #(
  parameter int ADDR_W = 8
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t              state_q;
  logic [1:0]          cnt_q;
  logic                write_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         asm_q;

  logic                reqReady_q;
  logic                respValid_q;
  logic                respErr_q;
  logic [31:0]         respRdata_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic                memRd_q;
  logic                memWr_q;
  logic [7:0]          memWdata_q;

  logic                lastByte;
  logic [1:0]          cntNext;
  logic [31:0]         asm_d;
  logic [31:0]         loadResult;

  function automatic logic [7:0] laneOf(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    laneOf = w[7:0];
      2'd1:    laneOf = w[15:8];
      2'd2:    laneOf = w[23:16];
      default: laneOf = w[31:24];
    endcase
  endfunction

  // The final byte is folded in here so the response can be registered on
  // the same edge that captures it.
  always_comb begin
    cntNext  = cnt_q + 2'd1;
    lastByte = (size_q == 2'b10) ||
               (size_q == 2'b01 && cnt_q == 2'd1) ||
               (cnt_q == 2'd3);
    asm_d = asm_q;
    if (!write_q) begin
      case (cnt_q)
        2'd0:    asm_d[7:0]   = mem_rdata;
        2'd1:    asm_d[15:8]  = mem_rdata;
        2'd2:    asm_d[23:16] = mem_rdata;
        default: asm_d[31:24] = mem_rdata;
      endcase
    end
    case (size_q)
      2'b00:   loadResult = asm_d;
      2'b01:   loadResult = {{16{signed_q & asm_d[15]}}, asm_d[15:0]};
      2'b10:   loadResult = {{24{signed_q & asm_d[7]}}, asm_d[7:0]};
      default: loadResult = 32'd0;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      asm_q       <= 32'd0;
      reqReady_q  <= 1'b1;
      respValid_q <= 1'b0;
      respErr_q   <= 1'b0;
      respRdata_q <= 32'd0;
      memAddr_q   <= '0;
      memRd_q     <= 1'b0;
      memWr_q     <= 1'b0;
      memWdata_q  <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            size_q     <= req_size;
            signed_q   <= req_signed;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            cnt_q      <= 2'd0;
            asm_q      <= 32'd0;
            reqReady_q <= 1'b0;
            if (req_size == 2'b11) begin
              state_q     <= RESP;
              respValid_q <= 1'b1;
              respErr_q   <= 1'b1;
              respRdata_q <= 32'd0;
            end else begin
              state_q    <= XFER;
              memAddr_q  <= req_addr;
              memRd_q    <= ~req_write;
              memWr_q    <= req_write;
              memWdata_q <= req_wdata[7:0];
            end
          end
        end
        XFER: begin
          asm_q <= asm_d;
          if (lastByte) begin
            state_q     <= RESP;
            memAddr_q   <= '0;
            memRd_q     <= 1'b0;
            memWr_q     <= 1'b0;
            memWdata_q  <= 8'd0;
            respValid_q <= 1'b1;
            respErr_q   <= 1'b0;
            respRdata_q <= write_q ? 32'd0 : loadResult;
          end else begin
            cnt_q      <= cntNext;
            memAddr_q  <= addr_q + ADDR_W'(cntNext);
            memWdata_q <= laneOf(wdata_q, cntNext);
          end
        end
        RESP: begin
          state_q     <= IDLE;
          respValid_q <= 1'b0;
          respErr_q   <= 1'b0;
          respRdata_q <= 32'd0;
          reqReady_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = reqReady_q;
  assign resp_valid = respValid_q;
  assign resp_err   = respErr_q;
  assign resp_rdata = respRdata_q;
  assign mem_addr   = memAddr_q;
  assign mem_rd     = memRd_q;
  assign mem_wr     = memWr_q;
  assign mem_wdata  = memWdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: a driver queues expected responses, a
// monitor pops them when resp_valid fires and checks bus invariants.
module tb_mem_lsu;

  logic        sclk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t       sbQ[$];
  logic [7:0] addrLog[$];
  logic [7:0] mem [256];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         strobeCnt = 0;
  logic       prevResp = 1'b0;
  logic       bdWe = 1'b0;
  logic [7:0] bdAddr = 8'd0;
  logic [7:0] bdData = 8'd0;

  mem_lsu #(.ADDR_W(8)) dut (
    .sclk(sclk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  always @(posedge sclk) cyc <= cyc + 1;

  // Single writer for the memory model: DUT byte writes plus bench preloads.
  always @(posedge sclk) begin
    if (mem_wr) mem[mem_addr] = mem_wdata;
    if (bdWe) mem[bdAddr] = bdData;
  end

  assign mem_rdata = mem[mem_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge sclk) begin
    if (rst_n) begin
      if (mem_rd || mem_wr) begin
        strobeCnt++;
        addrLog.push_back(mem_addr);
      end
      if (mem_rd && mem_wr) begin
        errors++;
        $display("[TB] FAIL strobe overlap: rd=%b wr=%b", mem_rd, mem_wr);
      end
      if (!mem_rd && !mem_wr && (mem_addr != 8'd0 || mem_wdata != 8'd0)) begin
        errors++;
        $display("[TB] FAIL idle bus: addr=%h wdata=%h, expected 00/00", mem_addr, mem_wdata);
      end
      if (resp_valid && prevResp) begin
        errors++;
        $display("[TB] FAIL adjacent resp_valid strobes at cycle %0d", cyc);
      end
      if (!resp_valid && (resp_err || resp_rdata != 32'd0)) begin
        errors++;
        $display("[TB] FAIL quiet resp: err=%b rdata=%h, expected 0", resp_err, resp_rdata);
      end
      if (resp_valid) begin
        if (sbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected resp_valid at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput("resp_rdata", resp_rdata, e.data);
          checkOutput("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          checkOutput("resp latency cycle", cyc, e.due);
        end
      end
    end
    prevResp = resp_valid && rst_n;
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge sclk);
    bdWe = 1'b1; bdAddr = a; bdData = d;
    @(negedge sclk);
    bdWe = 1'b0;
  endtask

  // Issues one request at the next idle opportunity; returns #1 after the accept edge.
  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [7:0] addr, input logic [31:0] wdata,
                               input logic [31:0] expData, input logic expErr,
                               input bit expectResp);
    int guard = 0;
    int n;
    exp_t e;
    @(negedge sclk);
    while (!req_ready && guard < 50) begin
      @(negedge sclk);
      guard++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("[TB] FAIL req_ready timeout: got 0, expected 1");
    end
    req_valid = 1'b1; req_write = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge sclk);
    #1;
    req_valid = 1'b0;
    n = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : (size == 2'b10) ? 1 : 0;
    if (expectResp) begin
      e.data = expData; e.err = expErr; e.due = cyc + n;
      sbQ.push_back(e);
    end
  endtask

  task automatic waitIdle();
    int guard = 0;
    @(negedge sclk);
    while (!(sbQ.size() == 0 && req_ready) && guard < 50) begin
      @(negedge sclk);
      guard++;
    end
    if (sbQ.size() != 0 || !req_ready) begin
      checks++; errors++;
      $display("[TB] FAIL idle timeout: pending=%0d ready=%b, expected 0/1", sbQ.size(), req_ready);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int strobeBase;
    int accepted;
    int prevAcc;
    int guard;
    logic wasReady;
    logic [7:0] streamBytes [4];
    exp_t e;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 8'd0; req_wdata = 32'd0;
    repeat (2) @(negedge sclk);
    checkOutput("reset req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("reset mem strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    checkOutput("reset mem_addr", {24'd0, mem_addr}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 2'b00, 1'b0, 8'h10, 32'hDEADBEEF, 32'd0, 1'b0, 1);
    waitIdle();
    checkOutput("SW mem 0x10..13", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h10, 32'd0, 32'hDEADBEEF, 1'b0, 1);
    waitIdle();

    preload(8'h20, 8'h01);
    preload(8'h21, 8'h80);
    applyStimulus(1'b0, 2'b01, 1'b1, 8'h20, 32'd0, 32'hFFFF8001, 1'b0, 1);
    applyStimulus(1'b0, 2'b01, 1'b0, 8'h20, 32'd0, 32'h00008001, 1'b0, 1);
    applyStimulus(1'b0, 2'b10, 1'b1, 8'h21, 32'd0, 32'hFFFFFF80, 1'b0, 1);
    applyStimulus(1'b0, 2'b10, 1'b0, 8'h21, 32'd0, 32'h00000080, 1'b0, 1);
    waitIdle();

    preload(8'h32, 8'h5A);
    applyStimulus(1'b1, 2'b01, 1'b0, 8'h30, 32'h12345678, 32'd0, 1'b0, 1);
    waitIdle();
    checkOutput("SH mem 0x30..32", {8'd0, mem[8'h32], mem[8'h31], mem[8'h30]}, 32'h005A5678);

    addrLog.delete();
    applyStimulus(1'b1, 2'b00, 1'b0, 8'hFE, 32'h11223344, 32'd0, 1'b0, 1);
    waitIdle();
    checkOutput("wrap mem bytes", {mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]}, 32'h11223344);
    checkOutput("wrap addr count", addrLog.size(), 32'd4);
    if (addrLog.size() == 4)
      checkOutput("wrap addr seq", {addrLog[0], addrLog[1], addrLog[2], addrLog[3]}, 32'hFEFF0001);

    strobeBase = strobeCnt;
    applyStimulus(1'b0, 2'b11, 1'b0, 8'h40, 32'd0, 32'd0, 1'b1, 1);
    @(negedge sclk);
    @(negedge sclk);
    checkOutput("illegal ready after resp", {31'd0, req_ready}, 32'd1);
    checkOutput("illegal strobes", strobeCnt, strobeBase);
    waitIdle();

    preload(8'h52, 8'h77);
    preload(8'h53, 8'h66);
    applyStimulus(1'b1, 2'b00, 1'b0, 8'h50, 32'hAABBCCDD, 32'd0, 1'b0, 0);
    @(posedge sclk);
    @(posedge sclk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort mem bus", {mem_rd, mem_wr, 6'd0, mem_addr, mem_wdata, 8'd0}, 32'd0);
    checkOutput("abort resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge sclk);
    @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);
    checkOutput("abort ready", {31'd0, req_ready}, 32'd1);
    checkOutput("abort mem 0x50..53", {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]}, 32'h6677CCDD);

    streamBytes[0] = 8'h11; streamBytes[1] = 8'h22;
    streamBytes[2] = 8'h33; streamBytes[3] = 8'h44;
    for (int i = 0; i < 4; i++) preload(8'(8'h60 + i), streamBytes[i]);
    @(negedge sclk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 8'h60;
    accepted = 0; prevAcc = 0; guard = 0;
    while (accepted < 4 && guard < 60) begin
      wasReady = req_ready;
      @(posedge sclk);
      #1;
      if (wasReady) begin
        e.data = {24'd0, streamBytes[accepted]}; e.err = 1'b0; e.due = cyc + 1;
        sbQ.push_back(e);
        if (accepted > 0) checkOutput("stream spacing", cyc - prevAcc, 32'd3);
        prevAcc = cyc;
        accepted++;
        req_addr = 8'(8'h60 + accepted);
        if (accepted == 4) req_valid = 1'b0;
      end
      @(negedge sclk);
      guard++;
    end
    req_valid = 1'b0;
    checkOutput("stream accepts", accepted, 32'd4);
    waitIdle();
    checkOutput("scoreboard drained", sbQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
